// File: rtl/regfile_pkg.sv
// Shared definitions for the register file port arbiter: register file geometry
// and the access FSM state encoding.
package regfile_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;
    localparam int RF_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arbiter.sv
// Combinational round-robin grant: picks the first set request bit starting at
// ptr and wrapping modulo NUM_REQ. The pointer itself is owned by the caller.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    int cand;

    // Rotating priority search; the first hit wins and later hits are ignored.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Sole driver of the single-port register file. Serializes requests from
// NUM_REQ requesters with a round-robin grant, issues one strobe per access and
// returns read data on a one-hot response pulse two cycles after the accept.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rf_rd,
    output logic                      rf_wn,
    output logic [ADDR_W-1:0]         rf_reg_id,
    output logic [DATA_W-1:0]         rf_write_data,
    input  logic [DATA_W-1:0]         rf_read_data,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t               state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     g_l;
    logic                 we_l;
    logic                 rd_q;
    logic                 wn_q;
    logic [NUM_REQ-1:0]   rsp_q;

    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [PTR_W-1:0]     ptr_next;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Pick out the granted requester's operands and the pointer that follows it.
    always_comb begin
        sel_we    = req_we[grant_idx];
        sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
        ptr_next  = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
    end

    // Access FSM: strobes and response pulse are registered one state ahead so
    // they appear exactly in the ACCESS and RESP cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            g_l           <= '0;
            we_l          <= 1'b0;
            rd_q          <= 1'b0;
            wn_q          <= 1'b0;
            rsp_q         <= '0;
            rf_reg_id     <= '0;
            rf_write_data <= '0;
        end else begin
            rd_q  <= 1'b0;
            wn_q  <= 1'b0;
            rsp_q <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state         <= ACCESS;
                        g_l           <= grant_idx;
                        we_l          <= sel_we;
                        rr_ptr        <= ptr_next;
                        rd_q          <= ~sel_we;
                        wn_q          <= sel_we;
                        rf_reg_id     <= sel_addr;
                        rf_write_data <= sel_we ? sel_wdata : '0;
                    end
                end
                ACCESS: begin
                    if (we_l) begin
                        state <= IDLE;
                    end else begin
                        state <= RESP;
                        rsp_q <= NUM_REQ'(1) << g_l;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Accept is combinational in IDLE; everything is forced quiet while reset
    // is high so an access interrupted by reset never strobes the register file.
    always_comb begin
        req_ready = (state == IDLE && !reset) ? grant : '0;
        rsp_valid = reset ? '0 : rsp_q;
        rsp_data  = (rsp_valid != '0) ? rf_read_data : '0;
        rf_rd     = rd_q & ~reset;
        rf_wn     = wn_q & ~reset;
        busy      = (state != IDLE) && !reset;
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed and random bench for regfile_arbiter with a behavioural 16x16
// register file (registered read) attached to its port.
module tb_regfile_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_we = '0;
    logic [N*4-1:0]  req_addr = '0;
    logic [N*16-1:0] req_wdata = '0;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [15:0]   rsp_data;
    logic          rf_rd;
    logic          rf_wn;
    logic [3:0]    rf_reg_id;
    logic [15:0]   rf_write_data;
    logic [15:0]   rf_read_data = '0;
    logic          busy;

    logic [15:0] rf_mem [16] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                                 16'hA004, 16'hA005, 16'hA006, 16'hA007,
                                 16'hA008, 16'hA009, 16'hA00A, 16'hA00B,
                                 16'hA00C, 16'hA00D, 16'hA00E, 16'hA00F};

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0]  gq [$];
    logic [3:0]  rvq [$];
    logic [15:0] rdq [$];

    regfile_arbiter #(.NUM_REQ(N), .DATA_W(16), .ADDR_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rf_rd         (rf_rd),
        .rf_wn         (rf_wn),
        .rf_reg_id     (rf_reg_id),
        .rf_write_data (rf_write_data),
        .rf_read_data  (rf_read_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural register file: writes and registered reads on posedge.
    always @(posedge clk) begin
        if (rf_wn) rf_mem[rf_reg_id] <= rf_write_data;
        if (rf_rd) rf_read_data <= rf_mem[rf_reg_id];
    end

    task automatic set_req(input int i, input logic we, input logic [3:0] a, input logic [15:0] d);
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*4 +: 4] = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Runs a fixed number of cycles, recording grants and responses and
    // dropping each requester's valid once it has been accepted.
    task automatic drain(input int ncyc);
        logic [3:0] got;
        gq.delete(); rvq.delete(); rdq.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            got = req_ready;
            if (req_ready != 4'b0) gq.push_back(req_ready);
            if (rsp_valid != 4'b0) begin
                rvq.push_back(rsp_valid);
                rdq.push_back(rsp_data);
            end
            @(posedge clk); #1;
            req_valid = req_valid & ~got;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({req_ready, rsp_valid, rsp_data, rf_rd, rf_wn} !== 26'd0) $display("FAIL reset_out ready=%b rsp=%b data=%h rd=%b wn=%b required all 0", req_ready, rsp_valid, rsp_data, rf_rd, rf_wn);
        else n_pass++;
        n_total++;
        if ({rf_reg_id, rf_write_data} !== 20'd0) $display("FAIL reset_rf id=%h wdata=%h required 0", rf_reg_id, rf_write_data);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b required 0", busy);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        set_req(1, 1'b1, 4'd5, 16'hBEEF);
        @(negedge clk);
        n_total++;
        if (req_ready !== 4'b0010) $display("FAIL wr_accept got=%b required 0010", req_ready);
        else n_pass++;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rf_wn, rf_rd, rf_reg_id, rf_write_data, busy} !== {1'b1, 1'b0, 4'd5, 16'hBEEF, 1'b1})
            $display("FAIL wr_strobe wn=%b rd=%b id=%h wd=%h busy=%b required 1 0 5 beef 1", rf_wn, rf_rd, rf_reg_id, rf_write_data, busy);
        else n_pass++;
        @(posedge clk); #1;
        set_req(1, 1'b0, 4'd5, 16'h0);
        @(negedge clk);
        n_total++;
        if (req_ready !== 4'b0010) $display("FAIL rd_accept got=%b required 0010", req_ready);
        else n_pass++;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rf_rd, rf_wn, rf_reg_id, rf_write_data} !== {1'b1, 1'b0, 4'd5, 16'h0})
            $display("FAIL rd_strobe rd=%b wn=%b id=%h wd=%h required 1 0 5 0000", rf_rd, rf_wn, rf_reg_id, rf_write_data);
        else n_pass++;
        n_total++;
        if (rsp_valid !== 4'b0) $display("FAIL rd_early_rsp got=%b required 0000", rsp_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 16'hBEEF) $display("FAIL rd_rsp valid=%b data=%h required 0010 beef", rsp_valid, rsp_data);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 4'b0 || rsp_data !== 16'h0) $display("FAIL rsp_idle valid=%b data=%h required 0000 0000", rsp_valid, rsp_data);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_all_reads();
        do_reset(2);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'(i), 16'h0);
        drain(16);
        n_total++;
        if (gq.size() != 4 || rvq.size() != 4) $display("FAIL rr_counts grants=%0d rsps=%0d required 4 4", gq.size(), rvq.size());
        else n_pass++;
        for (int k = 0; k < gq.size() && k < 4; k++) begin
            n_total++;
            if (gq[k] !== 4'(1 << k)) $display("FAIL rr_order[%0d] got=%b required %b", k, gq[k], 4'(1 << k));
            else n_pass++;
        end
        for (int k = 0; k < rvq.size() && k < 4; k++) begin
            n_total++;
            if (rvq[k] !== 4'(1 << k) || rdq[k] !== 16'hA000 + 16'(k))
                $display("FAIL rr_rsp[%0d] valid=%b data=%h required %b %h", k, rvq[k], rdq[k], 4'(1 << k), 16'hA000 + 16'(k));
            else n_pass++;
        end
    endtask

    task automatic test_write_then_read();
        set_req(2, 1'b1, 4'd7, 16'h1234);
        set_req(3, 1'b0, 4'd7, 16'h0);
        drain(12);
        n_total++;
        if (gq.size() != 2 || gq[0] !== 4'b0100 || gq[1] !== 4'b1000)
            $display("FAIL wr_rd_order grants=%0d first=%b required 2 0100", gq.size(), (gq.size() > 0) ? gq[0] : 4'b0);
        else n_pass++;
        n_total++;
        if (rvq.size() != 1 || rvq[0] !== 4'b1000 || rdq[0] !== 16'h1234)
            $display("FAIL wr_rd_rsp count=%0d data=%h required 1 1234", rvq.size(), (rdq.size() > 0) ? rdq[0] : 16'h0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        bit seen;
        set_req(1, 1'b0, 4'd2, 16'h0);
        @(negedge clk);
        n_total++;
        if (req_ready !== 4'b0010) $display("FAIL abort_accept got=%b required 0010", req_ready);
        else n_pass++;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (rf_rd !== 1'b0 || busy !== 1'b0) $display("FAIL abort_strobe rd=%b busy=%b required 0 0", rf_rd, busy);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid != 4'b0 || rf_rd || rf_wn) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL abort_quiet activity=%b required 0", seen);
        else n_pass++;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'd0, 16'h0);
        drain(16);
        n_total++;
        if (gq.size() != 4 || gq[0] !== 4'b0001) $display("FAIL abort_ptr grants=%0d first=%b required 4 0001", gq.size(), (gq.size() > 0) ? gq[0] : 4'b0);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] ref_mem [16];
        bit   [N-1:0] pend;
        int           waitcnt [N];
        logic [N-1:0] granted_last;
        int           mptr, hold, rsp_wait, j, gi;
        logic [N-1:0] exp_g;
        bit           exp_acc, exp_we;
        logic [3:0]   exp_addr;
        logic [15:0]  exp_wdata, exp_rdata;
        logic [N-1:0] exp_rvec;
        for (int i = 0; i < 16; i++) ref_mem[i] = rf_mem[i];
        pend = '0; granted_last = '0;
        mptr = 0; hold = 0; rsp_wait = 0; exp_acc = 0; exp_we = 0;
        exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_rvec = '0;
        for (int i = 0; i < N; i++) waitcnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (granted_last[i]) begin
                    req_valid[i] = 1'b0; pend[i] = 1'b0; waitcnt[i] = 0;
                end
                if (pend[i]) begin
                    if ($urandom_range(0, 15) == 0) begin
                        req_valid[i] = 1'b0; pend[i] = 1'b0; waitcnt[i] = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
                    pend[i] = 1'b1; waitcnt[i] = 0;
                end
            end
            @(negedge clk);
            n_total++;
            if (rf_rd && rf_wn) $display("FAIL rnd_both_strobes cycle=%0d rd=%b wn=%b required not both", c, rf_rd, rf_wn);
            else n_pass++;
            n_total++;
            if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) $display("FAIL rnd_onehot cycle=%0d ready=%b rsp=%b required onehot0", c, req_ready, rsp_valid);
            else n_pass++;
            n_total++;
            if (exp_acc) begin
                if (rf_rd !== !exp_we || rf_wn !== exp_we || rf_reg_id !== exp_addr || (exp_we && rf_write_data !== exp_wdata))
                    $display("FAIL rnd_strobe cycle=%0d rd=%b wn=%b id=%h wd=%h required we=%b id=%h wd=%h", c, rf_rd, rf_wn, rf_reg_id, rf_write_data, exp_we, exp_addr, exp_wdata);
                else n_pass++;
            end else begin
                if (rf_rd || rf_wn) $display("FAIL rnd_stray_strobe cycle=%0d rd=%b wn=%b required 0 0", c, rf_rd, rf_wn);
                else n_pass++;
            end
            exp_acc = 1'b0;
            n_total++;
            if (rsp_wait == 1) begin
                if (rsp_valid !== exp_rvec || rsp_data !== exp_rdata)
                    $display("FAIL rnd_rsp cycle=%0d valid=%b data=%h required %b %h", c, rsp_valid, rsp_data, exp_rvec, exp_rdata);
                else n_pass++;
            end else begin
                if (rsp_valid !== 4'b0) $display("FAIL rnd_stray_rsp cycle=%0d valid=%b required 0000", c, rsp_valid);
                else n_pass++;
            end
            if (rsp_wait > 0) rsp_wait--;
            exp_g = '0; gi = -1;
            if (hold == 0) begin
                for (int k = 0; k < N; k++) begin
                    j = (mptr + k) % N;
                    if (gi < 0 && req_valid[j]) gi = j;
                end
                if (gi >= 0) exp_g[gi] = 1'b1;
            end else begin
                hold--;
            end
            n_total++;
            if (req_ready !== exp_g) $display("FAIL rnd_grant cycle=%0d got=%b required %b", c, req_ready, exp_g);
            else n_pass++;
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (pend[i] && req_valid[i] && !req_ready[i]) begin
                        waitcnt[i]++;
                        n_total++;
                        if (waitcnt[i] > N - 1) $display("FAIL rnd_starve cycle=%0d req=%0d waited=%0d required <=%0d", c, i, waitcnt[i], N - 1);
                        else n_pass++;
                    end
                end
            end
            if (gi >= 0) begin
                mptr = (gi + 1) % N;
                exp_acc = 1'b1;
                exp_we = req_we[gi];
                exp_addr = req_addr[gi*4 +: 4];
                exp_wdata = req_wdata[gi*16 +: 16];
                if (exp_we) begin
                    ref_mem[exp_addr] = exp_wdata;
                    hold = 1;
                end else begin
                    exp_rdata = ref_mem[exp_addr];
                    exp_rvec = exp_g;
                    rsp_wait = 2;
                    hold = 2;
                end
            end
            granted_last = req_ready;
            @(posedge clk); #1;
        end
        req_valid = '0;
        drain(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout sim time exceeded required finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_all_reads();
        test_write_then_read();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
